commit_monitor: RTL

COMMIT_MONITOR -- requirements
Module: commit_monitor

---
 rtl/commit_monitor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/commit_monitor.sv
// Commit monitor: watches register-file writeback for a completion signature,
// bounds the run with a cycle budget and reports pass/fail plus retire statistics.
module commit_monitor #(
    parameter int unsigned       XLEN           = 64,
    parameter logic [4:0]        SIG_REG        = 5'd31,
    parameter logic [XLEN-1:0]   SIG_VALUE      = XLEN'(64'h7FF),
    parameter int unsigned       TIMEOUT_CYCLES = 1000,
    parameter int unsigned       DRAIN_CYCLES   = 10,
    parameter int unsigned       CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic [XLEN-1:0]  pc_f,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic [7:0]       x0_warn_count,
    output logic [XLEN-1:0]  fail_pc
);

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_TIMEOUT   = 2'b01;
    localparam logic [1:0] FC_MISALIGN  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] drain_cnt, drain_nxt;
    logic             done_nxt, pass_nxt;
    logic [1:0]       fail_code_nxt;
    logic [XLEN-1:0]  fail_pc_nxt;
    logic [CNT_W-1:0] cycle_nxt, retire_nxt;
    logic [7:0]       x0_warn_nxt;
    logic             count_en;
    logic             sig_hit;
    logic             misaligned;
    logic             timeout;

    assign sig_hit    = wb_we && (wb_rd == SIG_REG) && (wb_data == SIG_VALUE);
    assign misaligned = (pc_f[1:0] != 2'b00);
    assign timeout    = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state, status and counter updates
    always_comb begin
        state_nxt     = state;
        drain_nxt     = drain_cnt;
        done_nxt      = done;
        pass_nxt      = pass;
        fail_code_nxt = fail_code;
        fail_pc_nxt   = fail_pc;
        cycle_nxt     = cycle_count;
        retire_nxt    = retire_count;
        x0_warn_nxt   = x0_warn_count;
        count_en      = 1'b0;

        case (state)
            S_IDLE: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                count_en  = 1'b1;
                cycle_nxt = cycle_count + CNT_W'(1);
                if (sig_hit) begin
                    state_nxt = S_DRAIN;
                    drain_nxt = CNT_W'(DRAIN_CYCLES - 1);
                end else if (misaligned) begin
                    state_nxt     = S_FAIL;
                    done_nxt      = 1'b1;
                    fail_code_nxt = FC_MISALIGN;
                    fail_pc_nxt   = pc_f;
                    cycle_nxt     = cycle_count;
                end else if (timeout) begin
                    state_nxt     = S_FAIL;
                    done_nxt      = 1'b1;
                    fail_code_nxt = FC_TIMEOUT;
                    cycle_nxt     = cycle_count;
                end
            end
            S_DRAIN: begin
                count_en  = 1'b1;
                cycle_nxt = cycle_count + CNT_W'(1);
                if (drain_cnt == '0) begin
                    state_nxt = S_PASS;
                    done_nxt  = 1'b1;
                    pass_nxt  = 1'b1;
                end else begin
                    drain_nxt = drain_cnt - CNT_W'(1);
                end
            end
            S_PASS, S_FAIL: begin
                state_nxt = state;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Writes of zero to x0 are pipeline bubbles and are not counted at all
        if (count_en && wb_we) begin
            if (wb_rd != 5'd0) begin
                retire_nxt = retire_count + CNT_W'(1);
            end else if ((wb_data != '0) && (x0_warn_count != 8'hFF)) begin
                x0_warn_nxt = x0_warn_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            drain_cnt     <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail_code     <= FC_NONE;
            fail_pc       <= '0;
            cycle_count   <= '0;
            retire_count  <= '0;
            x0_warn_count <= '0;
        end else begin
            state         <= state_nxt;
            drain_cnt     <= drain_nxt;
            done          <= done_nxt;
            pass          <= pass_nxt;
            fail_code     <= fail_code_nxt;
            fail_pc       <= fail_pc_nxt;
            cycle_count   <= cycle_nxt;
            retire_count  <= retire_nxt;
            x0_warn_count <= x0_warn_nxt;
        end
    end

endmodule
